// File: rtl/hdb3_encoder.sv
// -----------------------------------------------------------------------------
// hdb3_encoder
//
// HDB3 line encoder producing dual unipolar rails. Each rising edge of the
// bit-rate clock (same domain as i_clk) is one bit slot. A bit enters a
// 4-symbol delay line. When a fourth consecutive zero arrives, the encoder
// substitutes either B00V or 000V, choosing whichever keeps successive
// violations alternating in polarity. The oldest symbol is then mapped onto
// the rails using AMI polarity.
//
// Ports:
//   i_clk       system clock
//   i_rst_n     asynchronous active-low reset
//   i_bit_clk   bit-rate clock; each rising edge is one bit slot
//   i_data      NRZ data bit, sampled in the tick cycle
//   o_pos       positive-pulse rail (held for the whole bit slot)
//   o_neg       negative-pulse rail (held for the whole bit slot)
//   o_sym_tick  one-cycle pulse in the cycle the rails update
// -----------------------------------------------------------------------------
module hdb3_encoder #(
    parameter logic FIRST_POS = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_bit_clk,
    input  logic i_data,
    output logic o_pos,
    output logic o_neg,
    output logic o_sym_tick
);

    typedef enum logic [1:0] {
        SYM_ZERO = 2'b00,
        SYM_ONE  = 2'b01,
        SYM_B    = 2'b10,
        SYM_V    = 2'b11
    } sym_e;

    logic       bclk_q;
    logic [1:0] zcnt_q,     zcnt_d;
    logic       par_q,      par_d;
    sym_e       stage_q [4];
    sym_e       stage_d [4];
    logic       last_neg_q, last_neg_d;
    logic       pos_q,      pos_d;
    logic       neg_q,      neg_d;
    logic       tick_q,     tick_d;

    logic       tick;
    sym_e       new_sym;
    logic       sub_b;

    // bclk_q resets high, so a bit clock that is already high when reset
    // releases does not count as a rising edge.
    assign tick = i_bit_clk & ~bclk_q;

    always_comb begin
        zcnt_d     = zcnt_q;
        par_d      = par_q;
        stage_d[0] = stage_q[0];
        stage_d[1] = stage_q[1];
        stage_d[2] = stage_q[2];
        stage_d[3] = stage_q[3];
        last_neg_d = last_neg_q;
        pos_d      = pos_q;
        neg_d      = neg_q;
        tick_d     = 1'b0;
        new_sym    = SYM_ZERO;
        sub_b      = 1'b0;

        if (tick) begin
            if (i_data) begin
                new_sym = SYM_ONE;
                zcnt_d  = 2'd0;
                par_d   = ~par_q;
            end else if (zcnt_q != 2'd3) begin
                new_sym = SYM_ZERO;
                zcnt_d  = zcnt_q + 2'd1;
            end else begin
                // Fourth zero in a row. With an even count of marks since the
                // last V, the oldest of the four zeros becomes a B. That B
                // sits in stage 2 right now and moves into stage 3 on this
                // edge.
                new_sym = SYM_V;
                zcnt_d  = 2'd0;
                par_d   = 1'b0;
                sub_b   = ~par_q;
            end

            stage_d[0] = new_sym;
            stage_d[1] = stage_q[0];
            stage_d[2] = stage_q[1];
            stage_d[3] = sub_b ? SYM_B : stage_q[2];

            // last_neg_q records the polarity of the previous B or ONE pulse.
            // A B or ONE takes the opposite polarity. A V repeats the
            // previous polarity and does not update last_neg_q.
            unique case (stage_q[3])
                SYM_ZERO: begin
                    pos_d = 1'b0;
                    neg_d = 1'b0;
                end
                SYM_ONE, SYM_B: begin
                    neg_d      = ~last_neg_q;
                    pos_d      = last_neg_q;
                    last_neg_d = ~last_neg_q;
                end
                SYM_V: begin
                    neg_d = last_neg_q;
                    pos_d = ~last_neg_q;
                end
                default: begin
                    pos_d = 1'b0;
                    neg_d = 1'b0;
                end
            endcase

            tick_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bclk_q     <= 1'b1;
            zcnt_q     <= 2'd0;
            par_q      <= 1'b0;
            stage_q[0] <= SYM_ZERO;
            stage_q[1] <= SYM_ZERO;
            stage_q[2] <= SYM_ZERO;
            stage_q[3] <= SYM_ZERO;
            last_neg_q <= FIRST_POS;
            pos_q      <= 1'b0;
            neg_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            bclk_q     <= i_bit_clk;
            zcnt_q     <= zcnt_d;
            par_q      <= par_d;
            stage_q[0] <= stage_d[0];
            stage_q[1] <= stage_d[1];
            stage_q[2] <= stage_d[2];
            stage_q[3] <= stage_d[3];
            last_neg_q <= last_neg_d;
            pos_q      <= pos_d;
            neg_q      <= neg_d;
            tick_q     <= tick_d;
        end
    end

    assign o_pos      = pos_q;
    assign o_neg      = neg_q;
    assign o_sym_tick = tick_q;

endmodule

// File: tb/tb_hdb3_encoder.sv
// -----------------------------------------------------------------------------
// tb_hdb3_encoder
//
// Directed bench for hdb3_encoder using the default parameter FIRST_POS = 1.
// Expected rail sequences are hand-derived HDB3 codes.
// Encoding used in the expected tables:
//   +1 = pulse on o_pos
//   -1 = pulse on o_neg
//    0 = no pulse
// -----------------------------------------------------------------------------
module tb_hdb3_encoder;

    logic i_clk = 1'b0;
    logic i_rst_n;
    logic i_bit_clk;
    logic i_data;
    logic o_pos;
    logic o_neg;
    logic o_sym_tick;

    int checks   = 0;
    int failures = 0;

    int bits_mixed [19] = '{1,0,0,0,0,1,1,0,0,0,0,0,0,0,0, 0,0,0,0};
    int exp_mixed  [15] = '{1,0,0,0,1,-1,1,-1,0,0,-1,1,0,0,1};
    int exp_zeros  [16] = '{1,0,0,1,-1,0,0,-1,1,0,0,1,-1,0,0,-1};
    int exp_ones   [8]  = '{1,-1,1,-1,1,-1,1,-1};
    int bits_pre   [6]  = '{0,1,0,0,1,0};
    int exp_pre    [6]  = '{0,0,0,0,0,1};
    int bits_post  [10] = '{0,0,0,0,1,1,0,0,0,0};
    int exp_post   [10] = '{0,0,0,0,1,0,0,1,-1,1};

    hdb3_encoder #(.FIRST_POS(1'b1)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_bit_clk  (i_bit_clk),
        .i_data     (i_data),
        .o_pos      (o_pos),
        .o_neg      (o_neg),
        .o_sym_tick (o_sym_tick)
    );

    always #10 i_clk = ~i_clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1);
    end

    task automatic apply_reset();
        i_rst_n   = 1'b0;
        i_bit_clk = 1'b1;
        i_data    = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        i_bit_clk = 1'b0;
        repeat (2) @(negedge i_clk);
    endtask

    // Raise the bit clock for one cycle. Returns at the negedge that follows
    // the registered update.
    task automatic do_tick(input int d);
        @(negedge i_clk);
        i_data    = (d != 0);
        i_bit_clk = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic end_tick();
        i_bit_clk = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        i_rst_n   = 1'b0;
        i_bit_clk = 1'b1;
        i_data    = 1'b1;
        repeat (3) @(negedge i_clk);
        checks++;
        if ({o_pos, o_neg, o_sym_tick} !== 3'b000) begin
            failures++;
            $display("FAIL reset_outputs: actual=%b required=000", {o_pos, o_neg, o_sym_tick});
        end
        i_rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge i_clk);
            checks++;
            if ({o_pos, o_neg, o_sym_tick} !== 3'b000) begin
                failures++;
                $display("FAIL bclk_high_release cyc %0d: actual=%b required=000", c, {o_pos, o_neg, o_sym_tick});
            end
        end
        i_bit_clk = 1'b0;
        i_data    = 1'b0;
        repeat (2) @(negedge i_clk);
    endtask

    task automatic test_mixed();
        int e;
        apply_reset();
        for (int k = 0; k < 19; k++) begin
            do_tick(bits_mixed[k]);
            e = (k < 4) ? 0 : exp_mixed[k-4];
            checks++;
            if ({o_sym_tick, o_pos, o_neg} !== {1'b1, e == 1, e == -1}) begin
                failures++;
                $display("FAIL mixed tick %0d: actual tick/pos/neg=%b required=%b", k+1,
                         {o_sym_tick, o_pos, o_neg}, {1'b1, e == 1, e == -1});
            end
            end_tick();
            checks++;
            if ({o_sym_tick, o_pos, o_neg} !== {1'b0, e == 1, e == -1}) begin
                failures++;
                $display("FAIL mixed hold %0d: actual tick/pos/neg=%b required=%b", k+1,
                         {o_sym_tick, o_pos, o_neg}, {1'b0, e == 1, e == -1});
            end
        end
    endtask

    task automatic test_zeros();
        int e;
        apply_reset();
        for (int k = 0; k < 20; k++) begin
            do_tick(0);
            e = (k < 4) ? 0 : exp_zeros[k-4];
            checks++;
            if ({o_sym_tick, o_pos, o_neg} !== {1'b1, e == 1, e == -1}) begin
                failures++;
                $display("FAIL zeros tick %0d: actual tick/pos/neg=%b required=%b", k+1,
                         {o_sym_tick, o_pos, o_neg}, {1'b1, e == 1, e == -1});
            end
            end_tick();
        end
    endtask

    task automatic test_ones();
        int e;
        apply_reset();
        for (int k = 0; k < 12; k++) begin
            do_tick(k < 8 ? 1 : 0);
            e = (k < 4) ? 0 : exp_ones[k-4];
            checks++;
            if ({o_sym_tick, o_pos, o_neg} !== {1'b1, e == 1, e == -1}) begin
                failures++;
                $display("FAIL ones tick %0d: actual tick/pos/neg=%b required=%b", k+1,
                         {o_sym_tick, o_pos, o_neg}, {1'b1, e == 1, e == -1});
            end
            checks++;
            if ((o_pos & o_neg) !== 1'b0) begin
                failures++;
                $display("FAIL ones both_rails %0d: actual=%b required=0", k+1, o_pos & o_neg);
            end
            end_tick();
        end
    endtask

    task automatic test_mid_reset();
        int e;
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            do_tick(bits_pre[k]);
            e = exp_pre[k];
            checks++;
            if ({o_pos, o_neg} !== {e == 1, e == -1}) begin
                failures++;
                $display("FAIL pre_reset tick %0d: actual pos/neg=%b required=%b", k+1,
                         {o_pos, o_neg}, {e == 1, e == -1});
            end
            end_tick();
        end
        #3;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_pos, o_neg, o_sym_tick} !== 3'b000) begin
            failures++;
            $display("FAIL mid_reset_async: actual=%b required=000", {o_pos, o_neg, o_sym_tick});
        end
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        for (int k = 0; k < 10; k++) begin
            do_tick(bits_post[k]);
            e = exp_post[k];
            checks++;
            if ({o_sym_tick, o_pos, o_neg} !== {1'b1, e == 1, e == -1}) begin
                failures++;
                $display("FAIL post_reset tick %0d: actual tick/pos/neg=%b required=%b", k+1,
                         {o_sym_tick, o_pos, o_neg}, {1'b1, e == 1, e == -1});
            end
            end_tick();
        end
    endtask

    // Divider with T = 25000: bit clock high for 25000 cycles and low for
    // 25000 cycles. Ticks are expected to be 50000 cycles apart.
    task automatic test_tick_spacing();
        int pulses;
        int first_at;
        int second_at;
        int width;
        int max_width;
        apply_reset();
        pulses    = 0;
        first_at  = -1;
        second_at = -1;
        width     = 0;
        max_width = 0;
        i_data    = 1'b0;
        for (int cyc = 0; cyc < 52000; cyc++) begin
            if (o_sym_tick === 1'b1) begin
                if (width == 0) begin
                    pulses++;
                    if (first_at < 0) first_at = cyc;
                    else if (second_at < 0) second_at = cyc;
                end
                width++;
                if (width > max_width) max_width = width;
            end else begin
                width = 0;
            end
            i_bit_clk = (((cyc / 25000) % 2) == 0);
            @(negedge i_clk);
        end
        i_bit_clk = 1'b0;
        checks++;
        if (pulses != 2) begin
            failures++;
            $display("FAIL spacing_count: actual=%0d required=2", pulses);
        end
        checks++;
        if (second_at - first_at != 50000) begin
            failures++;
            $display("FAIL spacing_interval: actual=%0d required=50000", second_at - first_at);
        end
        checks++;
        if (max_width != 1) begin
            failures++;
            $display("FAIL spacing_width: actual=%0d required=1", max_width);
        end
    endtask

    initial begin
        i_rst_n   = 1'b0;
        i_bit_clk = 1'b1;
        i_data    = 1'b0;
        test_reset();
        test_mixed();
        test_zeros();
        test_ones();
        test_mid_reset();
        test_tick_spacing();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
